// File: rtl/inst_pos_bridge.sv
// Converts the core's level-request / ack-pulse instruction fetch port into a
// valid/ready read command plus an always-accepted response channel, with a response timeout.
module inst_pos_bridge #(
   parameter int unsigned TIMEOUT        = 255,
   parameter bit          ADDR_ALIGN_CHK = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inst_pos_req_i,
   input  logic [31:0] inst_pos_addr_i,
   output logic        inst_pos_ack_o,
   output logic [31:0] inst_pos_data_o,
   output logic        inst_pos_error_o,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [31:0] cmd_addr_o,
   input  logic        rsp_valid_i,
   input  logic [31:0] rsp_data_i,
   input  logic        rsp_err_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK
   } state_t;

   // The counter value held during the last WAIT cycle before the timeout fires.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        r_err;
   logic [7:0]  r_cnt;
   logic        r_orphan;

   logic        w_misaligned;
   logic        w_cmd_fire;
   logic        w_rsp_take;

   assign w_misaligned = ADDR_ALIGN_CHK && (inst_pos_addr_i[1:0] != 2'b00);
   assign w_cmd_fire   = cmd_valid_o && cmd_ready_i;
   assign w_rsp_take   = rsp_valid_i && !r_orphan;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_data   <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_orphan <= 1'b0;
      end else begin
         // A response owed to a timed-out fetch is swallowed wherever it lands.
         if (r_orphan && rsp_valid_i) begin
            r_orphan <= 1'b0;
         end

         unique case (r_state)
            S_IDLE: begin
               if (inst_pos_req_i) begin
                  r_addr <= inst_pos_addr_i;
                  if (w_misaligned) begin
                     r_data  <= '0;
                     r_err   <= 1'b1;
                     r_state <= S_ACK;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (w_cmd_fire) begin
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A response arriving on the expiry cycle beats the timeout.
               if (w_rsp_take) begin
                  r_data  <= rsp_data_i;
                  r_err   <= rsp_err_i;
                  r_state <= S_ACK;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_data   <= '0;
                  r_err    <= 1'b1;
                  r_orphan <= 1'b1;
                  r_state  <= S_ACK;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign inst_pos_ack_o   = (r_state == S_ACK);
   assign inst_pos_data_o  = r_data;
   assign inst_pos_error_o = r_err;
   assign cmd_valid_o      = (r_state == S_ISSUE) && !r_orphan;
   assign cmd_addr_o       = r_addr;
   assign busy_o           = (r_state != S_IDLE) || r_orphan;

endmodule

// File: tb/tb_inst_pos_bridge.sv
// Scoreboarded bench for inst_pos_bridge: expected acks are queued as fetches are
// driven and matched by a monitor when the bridge pulses ack.
module tb_inst_pos_bridge;

   logic        clk_i;
   logic        rst_ni;
   logic        inst_pos_req_i;
   logic [31:0] inst_pos_addr_i;
   logic        inst_pos_ack_o;
   logic [31:0] inst_pos_data_o;
   logic        inst_pos_error_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [31:0] cmd_addr_o;
   logic        rsp_valid_i;
   logic [31:0] rsp_data_i;
   logic        rsp_err_i;
   logic        busy_o;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        chk_data;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic prev_ack = 1'b0;

   inst_pos_bridge #(
      .TIMEOUT        (4),
      .ADDR_ALIGN_CHK (1'b1)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .inst_pos_req_i   (inst_pos_req_i),
      .inst_pos_addr_i  (inst_pos_addr_i),
      .inst_pos_ack_o   (inst_pos_ack_o),
      .inst_pos_data_o  (inst_pos_data_o),
      .inst_pos_error_o (inst_pos_error_o),
      .cmd_valid_o      (cmd_valid_o),
      .cmd_ready_i      (cmd_ready_i),
      .cmd_addr_o       (cmd_addr_o),
      .rsp_valid_i      (rsp_valid_i),
      .rsp_data_i       (rsp_data_i),
      .rsp_err_i        (rsp_err_i),
      .busy_o           (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic e, input logic chk);
      exp_t x;
      x.data     = d;
      x.err      = e;
      x.chk_data = chk;
      sb_q.push_back(x);
   endtask

   // Every ack must be a single-cycle pulse that matches the oldest queued expectation.
   always @(negedge clk_i) begin
      if (inst_pos_ack_o) begin
         check_val("ack_width", {31'd0, prev_ack}, 32'd0);
         if (sb_q.size() == 0) begin
            check_val("unexpected_ack", {31'd0, inst_pos_ack_o}, 32'd0);
         end else begin
            exp_t x;
            x = sb_q.pop_front();
            $display("ack: data=0x%08h err=%0d (exp data=0x%08h err=%0d)",
                     inst_pos_data_o, inst_pos_error_o, x.data, x.err);
            if (x.chk_data) check_val("ack_data", inst_pos_data_o, x.data);
            check_val("ack_err", {31'd0, inst_pos_error_o}, {31'd0, x.err});
         end
      end
      prev_ack = inst_pos_ack_o;
   end

   // Aligned fetch: stall cycles with cmd_ready low, then rwait WAIT cycles before the response.
   task automatic fetch(input logic [31:0] a, input int stall, input int rwait,
                        input logic [31:0] rd, input logic re);
      push_exp(rd, re, 1'b1);
      inst_pos_req_i  = 1'b1;
      inst_pos_addr_i = a;
      cmd_ready_i     = 1'b0;
      tick();
      check_val("cmd_valid", {31'd0, cmd_valid_o}, 32'd1);
      check_val("cmd_addr", cmd_addr_o, a);
      for (int i = 0; i < stall; i++) begin
         tick();
         check_val("stall_valid", {31'd0, cmd_valid_o}, 32'd1);
         check_val("stall_addr", cmd_addr_o, a);
      end
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
      check_val("cmd_drop", {31'd0, cmd_valid_o}, 32'd0);
      for (int i = 0; i < rwait; i++) begin
         check_val("wait_no_ack", {31'd0, inst_pos_ack_o}, 32'd0);
         tick();
      end
      rsp_valid_i = 1'b1;
      rsp_data_i  = rd;
      rsp_err_i   = re;
      tick();
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
      rsp_err_i   = 1'b0;
      check_val("ack_lat", {31'd0, inst_pos_ack_o}, 32'd1);
      tick();
      check_val("ack_end", {31'd0, inst_pos_ack_o}, 32'd0);
      inst_pos_req_i  = 1'b0;
      inst_pos_addr_i = $urandom;
      tick();
   endtask

   initial begin
      rst_ni          = 1'b0;
      inst_pos_req_i  = 1'b0;
      inst_pos_addr_i = 32'h0;
      cmd_ready_i     = 1'b0;
      rsp_valid_i     = 1'b0;
      rsp_data_i      = 32'h0;
      rsp_err_i       = 1'b0;
      repeat (3) tick();
      check_val("rst_ack", {31'd0, inst_pos_ack_o}, 32'd0);
      check_val("rst_data", inst_pos_data_o, 32'h0);
      check_val("rst_err", {31'd0, inst_pos_error_o}, 32'd0);
      check_val("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
      check_val("rst_busy", {31'd0, busy_o}, 32'd0);
      rst_ni = 1'b1;
      tick();

      // Basic fetch, response two WAIT cycles after acceptance.
      fetch(32'h0000_0100, 0, 2, 32'h0000_0013, 1'b0);
      repeat (3) tick();
      check_val("hold_data", inst_pos_data_o, 32'h0000_0013);
      check_val("idle_busy", {31'd0, busy_o}, 32'd0);

      // Misaligned fetch acks next cycle with error and never issues.
      push_exp(32'h0, 1'b1, 1'b0);
      inst_pos_req_i  = 1'b1;
      inst_pos_addr_i = 32'h0000_0102;
      cmd_ready_i     = 1'b1;
      tick();
      check_val("mis_ack", {31'd0, inst_pos_ack_o}, 32'd1);
      check_val("mis_no_cmd", {31'd0, cmd_valid_o}, 32'd0);
      tick();
      check_val("mis_no_cmd2", {31'd0, cmd_valid_o}, 32'd0);
      inst_pos_req_i = 1'b0;
      cmd_ready_i    = 1'b0;
      tick();
      check_val("mis_no_cmd3", {31'd0, cmd_valid_o}, 32'd0);

      // Command stalled for 5 cycles, then a minimum-latency fetch carrying a bus error.
      fetch(32'h0000_0200, 5, 1, 32'h1234_5678, 1'b0);
      fetch(32'h0000_0300, 0, 0, 32'hA5A5_0001, 1'b1);

      // Timeout after 4 WAIT cycles, then orphaned response is discarded.
      push_exp(32'h0, 1'b1, 1'b1);
      inst_pos_req_i  = 1'b1;
      inst_pos_addr_i = 32'h0000_0400;
      tick();
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_val("to_no_ack", {31'd0, inst_pos_ack_o}, 32'd0);
         tick();
      end
      check_val("to_no_ack", {31'd0, inst_pos_ack_o}, 32'd0);
      tick();
      check_val("to_ack", {31'd0, inst_pos_ack_o}, 32'd1);
      tick();
      inst_pos_req_i = 1'b0;
      check_val("orphan_busy", {31'd0, busy_o}, 32'd1);
      tick();
      inst_pos_req_i  = 1'b1;
      inst_pos_addr_i = 32'h0000_0500;
      cmd_ready_i     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("orphan_hold_cmd", {31'd0, cmd_valid_o}, 32'd0);
      end
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'hDEAD_BEEF;
      tick();
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
      check_val("orphan_no_ack", {31'd0, inst_pos_ack_o}, 32'd0);
      check_val("orphan_data_kept", inst_pos_data_o, 32'h0);
      check_val("orphan_cmd_go", {31'd0, cmd_valid_o}, 32'd1);
      check_val("orphan_cmd_addr", cmd_addr_o, 32'h0000_0500);
      push_exp(32'h0000_0517, 1'b0, 1'b1);
      tick();
      cmd_ready_i = 1'b0;
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'h0000_0517;
      tick();
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
      check_val("second_ack", {31'd0, inst_pos_ack_o}, 32'd1);
      tick();
      inst_pos_req_i = 1'b0;
      tick();

      // Response on the expiry cycle wins; no orphan left behind.
      push_exp(32'hCAFE_0001, 1'b1, 1'b1);
      inst_pos_req_i  = 1'b1;
      inst_pos_addr_i = 32'h0000_0600;
      tick();
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
      repeat (3) tick();
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'hCAFE_0001;
      rsp_err_i   = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
      rsp_err_i   = 1'b0;
      check_val("edge_ack", {31'd0, inst_pos_ack_o}, 32'd1);
      tick();
      inst_pos_req_i = 1'b0;
      check_val("edge_no_orphan", {31'd0, busy_o}, 32'd0);
      tick();

      // Reset while in WAIT abandons the fetch; a stray response afterwards is ignored.
      inst_pos_req_i  = 1'b1;
      inst_pos_addr_i = 32'h0000_0700;
      tick();
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
      tick();
      check_val("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      rst_ni         = 1'b0;
      inst_pos_req_i = 1'b0;
      #1;
      check_val("arst_busy", {31'd0, busy_o}, 32'd0);
      check_val("arst_data", inst_pos_data_o, 32'h0);
      check_val("arst_err", {31'd0, inst_pos_error_o}, 32'd0);
      check_val("arst_cmd", {31'd0, cmd_valid_o}, 32'd0);
      check_val("arst_ack", {31'd0, inst_pos_ack_o}, 32'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'h0000_0BAD;
      tick();
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
      check_val("stray_no_ack", {31'd0, inst_pos_ack_o}, 32'd0);
      check_val("stray_busy", {31'd0, busy_o}, 32'd0);
      check_val("stray_data", inst_pos_data_o, 32'h0);
      tick();

      fetch(32'h0000_0800, 1, 0, 32'h0BAD_F00D, 1'b0);
      repeat (2) tick();
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_pos_bridge.md
INST_POS_BRIDGE -- requirements
Module: inst_pos_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waited in WAIT for a response (1..255).
REQ-002 SHALL have parameter ADDR_ALIGN_CHK, default 1, 1 = flag word-misaligned fetches as errors.
REQ-003 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_pos_req_i  input  1  fetch request, level, held until the cycle after ack.
REQ-006 SHALL have port inst_pos_addr_i  input  32  fetch address, valid while req high.
REQ-007 SHALL have port inst_pos_ack_o  output  1  one-cycle completion pulse.
REQ-008 SHALL have port inst_pos_data_o  output  32  fetched instruction, valid with ack.
REQ-009 SHALL have port inst_pos_error_o  output  1  fetch error, valid with ack.
REQ-010 SHALL have port cmd_valid_o  output  1  fabric read command valid.
REQ-011 SHALL have port cmd_ready_i  input  1  fabric accepts command.
REQ-012 SHALL have port cmd_addr_o  output  32  fabric read address.
REQ-013 SHALL have port rsp_valid_i  input  1  fabric response valid (always accepted).
REQ-014 SHALL have port rsp_data_i  input  32  response data.
REQ-015 SHALL have port rsp_err_i  input  1  response bus error.
REQ-016 SHALL have port busy_o  output  1  high whenever FSM not in IDLE or orphan pending.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK.
REQ-018 IDLE: on req_i=1 SHALL capture addr_i into addr register; go to ACK with error if ADDR_ALIGN_CHK=1 and addr_i[1:0]!=0, else go to ISSUE.
REQ-019 ISSUE: cmd_valid_o SHALL be 1 iff orphan flag is 0; cmd_addr_o SHALL equal captured address; on cmd_valid_o & cmd_ready_i go to WAIT; no timeout in ISSUE.
REQ-020 cmd_valid_o once asserted SHALL stay high with stable cmd_addr_o until cmd_ready_i.
REQ-021 WAIT: 8-bit counter cleared on entry, increments each cycle without rsp_valid_i; on rsp_valid_i go to ACK latching rsp_data_i, rsp_err_i.
REQ-022 WAIT: when counter reaches TIMEOUT with no rsp_valid_i, SHALL go to ACK with error=1, data=0, and set orphan flag.
REQ-023 rsp_valid_i in the same cycle as timeout expiry SHALL win: response latched, orphan not set.
REQ-024 ACK: inst_pos_ack_o=1 for exactly one cycle, data/error from registers; next state IDLE unconditionally.
REQ-025 In ACK and the first IDLE cycle after it, req_i is still high/being dropped; FSM SHALL NOT accept req in ACK; re-acceptance only in IDLE.
REQ-026 Orphan flag SHALL clear on any rsp_valid_i while set; that response SHALL be discarded (no ack, no data update) in any state.
REQ-027 rsp_valid_i outside WAIT with orphan=0 SHALL be ignored.
REQ-028 inst_pos_data_o and inst_pos_error_o SHALL hold last values between acks.
REQ-029 Ack latency: misaligned 1 cycle after req seen; normal = 1 (ISSUE) + cmd wait + response wait + 1 (ACK); minimum 3 cycles with cmd_ready_i=1 and rsp_valid_i the cycle after acceptance.
REQ-030 Outputs SHALL be registered or decoded from state only; no combinational path from fabric inputs to core outputs.

Reset
REQ-031 Reset SHALL force state IDLE, orphan=0, counter=0, addr=0, ack_o=0, data_o=0, error_o=0, cmd_valid_o=0, busy_o=0.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no ack; a later fabric response SHALL be ignored (orphan=0).

Verification
REQ-033 req addr 0x0000_0100, cmd_ready=1, rsp after 2 cycles data 0x0000_0013 -> single ack pulse, data 0x13, error 0.
REQ-034 req addr 0x0000_0102 -> ack 1 cycle later, error 1, no cmd_valid ever asserted.
REQ-035 cmd_ready low 5 cycles -> cmd_valid and cmd_addr stable throughout, no timeout, completes normally.
REQ-036 TIMEOUT=4, no rsp -> ack error 1 data 0 after 4 WAIT cycles; next req holds cmd_valid low until late rsp 0xDEAD_BEEF arrives, which is discarded; second fetch then returns its own data.
REQ-037 rsp_valid exactly at timeout cycle with rsp_err=1 -> ack error 1 with rsp data, orphan stays 0.
REQ-038 rst_ni low while in WAIT -> all outputs reset immediately; subsequent stray rsp produces no ack.
